// File: rtl/osd_du_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : osd_du_arbiter_if
// Description : Requester-side and core-DU-side signal bundle for the debug
//               unit arbiter. The slave modport is the arbiter's view and the
//               master modport is the environment's view (debug modules plus
//               core DU pins).
// Revision    : 1.0 - initial release
// ============================================================================
interface osd_du_arbiter_if #(
  parameter int NREQ = 2
);
  // Requester side
  logic [NREQ-1:0]    req_stb;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*16-1:0] req_adr;
  logic [NREQ*32-1:0] req_wdat;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    req_err;
  logic [31:0]        req_rdat;
  logic [NREQ-1:0]    req_stall;

  // Core DU side (names follow the core's pin names)
  logic               du_stall_i;
  logic               du_stall_o;
  logic               du_stb_i;
  logic               du_ack_o;
  logic [15:0]        du_adr_i;
  logic               du_we_i;
  logic [31:0]        du_dat_i;
  logic [31:0]        du_dat_o;

  // Status
  logic               stall_evt;
  logic               busy;

  modport slave (
    input  req_stb, req_we, req_adr, req_wdat, req_stall,
    input  du_stall_o, du_ack_o, du_dat_o,
    output req_ack, req_err, req_rdat,
    output du_stall_i, du_stb_i, du_adr_i, du_we_i, du_dat_i,
    output stall_evt, busy
  );

  modport master (
    output req_stb, req_we, req_adr, req_wdat, req_stall,
    output du_stall_o, du_ack_o, du_dat_o,
    input  req_ack, req_err, req_rdat,
    input  du_stall_i, du_stb_i, du_adr_i, du_we_i, du_dat_i,
    input  stall_evt, busy
  );
endinterface
`default_nettype wire

// File: rtl/osd_du_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : osd_du_arbiter
// Description : Round-robin arbiter sharing one core debug-unit SPR port
//               between NREQ debug requesters. One transaction in flight,
//               merged stall request and a one-cycle breakpoint-entry event.
//               Optional feature macro: OSD_DU_ARB_TIMEOUT_EN enables the
//               ISSUE timeout counter and the req_err abort path.
// Revision    : 1.0 - initial release
// ============================================================================
module osd_du_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  osd_du_arbiter_if.slave  du_bus
);

  localparam int            IW     = $clog2(NREQ);
  localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);

  // Supported ranges are NREQ 2..8 and TIMEOUT 1..65535; this block is a
  // marker only and elaborates to nothing.
  if ((NREQ < 2) || (NREQ > 8) || (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_param_out_of_range
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   last_grant_q;
  logic            we_q;
  logic [15:0]     adr_q;
  logic [31:0]     wdat_q;
  logic [31:0]     rdat_q;
  logic            stall_q;
  logic            stall_dly_q;
  logic            evt_q;
  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic            timeout_hit;

`ifdef OSD_DU_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  logic [15:0]     cnt_q;
  logic            err_q;
`endif

  // Round-robin pick: scan from last_grant+1 upward, wrapping at NREQ.
  always_comb begin
    logic [IW:0] j;
    grant_found = 1'b0;
    grant_idx   = '0;
    j           = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = {1'b0, last_grant_q} + (IW+1)'(k);
      if (j >= NREQ_W) j = j - NREQ_W;
      if (!grant_found && du_bus.req_stb[j[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = j[IW-1:0];
      end
    end
  end

  // Next-state logic; an ack in the final counted cycle beats the timeout.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE:  if (grant_found) state_d = ISSUE;
      ISSUE: begin
        if (du_bus.du_ack_o) begin
          state_d = RESP;
        end
`ifdef OSD_DU_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          timeout_hit = 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus latched transaction, read data and grant history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      last_grant_q <= IW'(NREQ - 1);
      we_q         <= 1'b0;
      adr_q        <= '0;
      wdat_q       <= '0;
      rdat_q       <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && grant_found) begin
        idx_q  <= grant_idx;
        we_q   <= du_bus.req_we[grant_idx];
        adr_q  <= du_bus.req_adr[{grant_idx, 4'b0000} +: 16];
        wdat_q <= du_bus.req_wdat[{grant_idx, 5'b00000} +: 32];
      end
      if ((state_q == ISSUE) && du_bus.du_ack_o && !we_q) begin
        rdat_q <= du_bus.du_dat_o;
      end
      if ((state_q == ISSUE) && (state_d == RESP)) begin
        last_grant_q <= idx_q;
      end
    end
  end

`ifdef OSD_DU_ARB_TIMEOUT_EN
  // Cycle counter held at zero outside ISSUE; err flag marks an aborted RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ISSUE) ? cnt_q + 16'd1 : 16'd0;
      if ((state_q == ISSUE) && (state_d == RESP)) err_q <= timeout_hit;
    end
  end
`endif

  // Stall merge and rising-edge detect of the core's stopped indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q     <= 1'b0;
      stall_dly_q <= 1'b0;
      evt_q       <= 1'b0;
    end else begin
      stall_q     <= |du_bus.req_stall;
      stall_dly_q <= du_bus.du_stall_o;
      evt_q       <= du_bus.du_stall_o & ~stall_dly_q;
    end
  end

  // Completion pulses decoded from RESP so reset clears them immediately.
  for (genvar i = 0; i < NREQ; i++) begin : g_resp
`ifdef OSD_DU_ARB_TIMEOUT_EN
    assign du_bus.req_ack[i] = (state_q == RESP) && (idx_q == IW'(i)) && !err_q;
    assign du_bus.req_err[i] = (state_q == RESP) && (idx_q == IW'(i)) &&  err_q;
`else
    assign du_bus.req_ack[i] = (state_q == RESP) && (idx_q == IW'(i));
    assign du_bus.req_err[i] = 1'b0;
`endif
  end

  assign du_bus.du_stb_i   = (state_q == ISSUE);
  assign du_bus.du_adr_i   = adr_q;
  assign du_bus.du_we_i    = we_q;
  assign du_bus.du_dat_i   = wdat_q;
  assign du_bus.req_rdat   = rdat_q;
  assign du_bus.du_stall_i = stall_q;
  assign du_bus.stall_evt  = evt_q;
  assign du_bus.busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_osd_du_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_osd_du_arbiter
// Description : Self-checking bench for osd_du_arbiter: vector table of
//               single transactions, hand sequences for timeout, stall,
//               reset-in-ISSUE and contention, then randomized traffic
//               checked against a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_du_arbiter;

  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  osd_du_arbiter_if #(.NREQ(NREQ)) bus ();

  osd_du_arbiter #(.NREQ(NREQ), .TIMEOUT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .du_bus (bus)
  );

  // Bench-owned drive state
  logic [NREQ-1:0]    stb_m   = '0;
  logic [NREQ-1:0]    we_v    = '0;
  logic [NREQ*16-1:0] adr_v   = '0;
  logic [NREQ*32-1:0] wdat_v  = '0;
  logic [NREQ-1:0]    stall_v = '0;
  logic               ack_r   = 1'b0;
  logic [31:0]        dat_r   = '0;
  logic               dstall_r = 1'b0;

  assign bus.req_stb    = stb_m;
  assign bus.req_we     = we_v;
  assign bus.req_adr    = adr_v;
  assign bus.req_wdat   = wdat_v;
  assign bus.req_stall  = stall_v;
  assign bus.du_ack_o   = ack_r;
  assign bus.du_dat_o   = dat_r;
  assign bus.du_stall_o = dstall_r;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          last_g = NREQ - 1;
  logic [31:0] m_rdat = '0;

  typedef struct {
    int          req;
    bit          we;
    logic [15:0] adr;
    logic [31:0] wdat;
    int          lat;
    logic [31:0] rd;
    int          exp_win;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(last_g + k) % NREQ]) return (last_g + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit we, input logic [15:0] adr, input logic [31:0] wd);
    we_v[i]            = we;
    adr_v[16*i +: 16]  = adr;
    wdat_v[32*i +: 32] = wd;
    stb_m[i]           = 1'b1;
  endtask

  // One DU transaction: wait for strobe, check DU fields, ack after lat cycles,
  // check the completion cycle, then drop the winner's request.
  task automatic txn(input string nm, input int exp_win, input int lat,
                     input logic [31:0] rd, input logic [31:0] exp_rdat, input int exp_wait);
    int              n;
    logic [48:0]     exp_bus;
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[exp_win] = 1'b1;
    exp_bus = {adr_v[16*exp_win +: 16], we_v[exp_win], wdat_v[32*exp_win +: 32]};
    n = 0;
    while (!bus.du_stb_i && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_wait"}, 64'(n), 64'(exp_wait));
    if (!bus.du_stb_i) return;
    chk({nm, "_du_fields"}, {15'd0, bus.du_adr_i, bus.du_we_i, bus.du_dat_i}, {15'd0, exp_bus});
    repeat (lat) tick();
    chk({nm, "_hold"}, {bus.du_stb_i, bus.req_ack, bus.req_err}, {1'b1, 3'b000, 3'b000});
    ack_r = 1'b1;
    dat_r = rd;
    tick();
    ack_r = 1'b0;
    dat_r = $urandom;
    chk({nm, "_ack"}, {bus.req_ack, bus.req_err}, {oh, 3'b000});
    chk({nm, "_rdat"}, bus.req_rdat, exp_rdat);
    chk({nm, "_resp_stb"}, {bus.du_stb_i, bus.busy}, 2'b01);
    stb_m[exp_win] = 1'b0;
  endtask

  initial begin
    int order[4];
    int pulses;
    int n;
    bit ack_seen;

    vecs[0] = '{0, 1'b0, 16'h8010, 32'h0000_0000, 2, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 16'h8004, 32'h1234_5678, 0, 32'h0BAD_F00D, 1, 32'hDEAD_BEEF};
    vecs[2] = '{2, 1'b0, 16'h0001, 32'hFFFF_0000, 1, 32'hA5A5_A5A5, 2, 32'hA5A5_A5A5};
    vecs[3] = '{2, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 3, 32'h0000_0000, 2, 32'hA5A5_A5A5};
    vecs[4] = '{0, 1'b0, 16'h0000, 32'h0000_0001, 0, 32'h1357_9BDF, 0, 32'h1357_9BDF};
    order   = '{0, 1, 0, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {bus.du_stb_i, bus.busy, bus.req_ack, bus.req_err, bus.du_stall_i, bus.stall_evt}, 10'd0);
    chk("reset_data", {bus.du_adr_i, bus.du_we_i, bus.req_rdat}, 49'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table of single-requester transactions
    for (int v = 0; v < 5; v++) begin
      chk("idle_busy", bus.busy, 1'b0);
      set_req(vecs[v].req, vecs[v].we, vecs[v].adr, vecs[v].wdat);
      txn("vec", vecs[v].exp_win, vecs[v].lat, vecs[v].rd, vecs[v].exp_rdat, 1);
      last_g = vecs[v].exp_win;
      m_rdat = vecs[v].exp_rdat;
      tick();
    end

`ifdef OSD_DU_ARB_TIMEOUT_EN
    // Timeout: strobe for exactly TIMEOUT cycles, then an err pulse only
    set_req(0, 1'b0, 16'h8020, 32'h0);
    tick();
    n = 0;
    ack_seen = 1'b0;
    while (bus.du_stb_i && n < 20) begin
      if (bus.req_ack != '0) ack_seen = 1'b1;
      tick();
      n++;
    end
    chk("to_stb_cycles", 64'(n), 64'd4);
    chk("to_err", {bus.req_err, bus.req_ack}, {3'b001, 3'b000});
    chk("to_rdat", bus.req_rdat, m_rdat);
    stb_m[0] = 1'b0;
    last_g   = 0;
    tick();
    chk("to_clear", {bus.busy, bus.req_err, bus.req_ack, ack_seen}, 8'd0);
    set_req(1, 1'b0, 16'h8030, 32'h0);
    txn("to_next", 1, 1, 32'h600D_CAFE, 32'h600D_CAFE, 1);
    last_g = 1;
    m_rdat = 32'h600D_CAFE;
    tick();
`endif

    // Stall merge and breakpoint-entry pulse
    stall_v = 3'b010;
    chk("stall_lag", bus.du_stall_i, 1'b0);
    tick();
    chk("stall_set", bus.du_stall_i, 1'b1);
    dstall_r = 1'b1;
    chk("evt_pre", bus.stall_evt, 1'b0);
    tick();
    chk("evt_pulse", bus.stall_evt, 1'b1);
    pulses = 0;
    repeat (5) begin
      tick();
      if (bus.stall_evt) pulses++;
    end
    chk("evt_single", 64'(pulses), 64'd0);
    stall_v  = '0;
    dstall_r = 1'b0;
    tick();
    chk("stall_clear", {bus.du_stall_i, bus.stall_evt}, 2'b00);

    // Reset while ISSUE is active
    set_req(1, 1'b1, 16'h4444, 32'h5555_5555);
    tick();
    chk("pre_rst_stb", bus.du_stb_i, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_ctl", {bus.du_stb_i, bus.busy, bus.req_ack, bus.req_err, bus.du_we_i, bus.du_adr_i}, 25'd0);
    chk("rst_async_data", {bus.du_dat_i, bus.req_rdat}, 64'd0);
    stb_m  = '0;
    last_g = NREQ - 1;
    m_rdat = '0;
    set_req(0, 1'b0, 16'h1000, 32'h0);
    set_req(1, 1'b0, 16'h1001, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Contention: 0 and 1 both pending, each re-requests after the first ack
    for (int t = 0; t < 4; t++) begin
      txn("cont", order[t], 1, 32'hC0DE_0000 + 32'(t), 32'hC0DE_0000 + 32'(t), (t == 0) ? 1 : 2);
      last_g = order[t];
      m_rdat = 32'hC0DE_0000 + 32'(t);
      if (t < 2) set_req(order[t], 1'b0, 16'h1000 + 16'(order[t]), 32'h0);
    end

    // Randomized traffic against the round-robin model
    for (int t = 0; t < 150; t++) begin
      int          w;
      int          ew;
      int          lat;
      logic [31:0] rd;
      logic [31:0] er;
      logic [NREQ-1:0] m;
      if (stb_m == '0) begin
        tick();
        m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++)
          if (m[i]) set_req(i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
        ew = 1;
      end else begin
        ew = 2;
      end
      w   = rr_pick(stb_m);
      lat = $urandom_range(0, 3);
      rd  = $urandom;
      er  = we_v[w] ? m_rdat : rd;
      txn("rnd", w, lat, rd, er, ew);
      m_rdat = er;
      last_g = w;
      for (int i = 0; i < NREQ; i++)
        if (!stb_m[i] && ($urandom_range(0, 1) == 1))
          set_req(i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
